// File: rtl/dc_ipu_shr_hdecim2.sv
// Horizontal 2:1 decimator: averages pixel pairs per component, one output per pair.
// A line-sampled bypass flag passes pixels through unchanged.
module dc_ipu_shr_hdecim2 #(
    parameter int WIDTH = 8,
    parameter int COMP  = 3
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  clr,
    input  logic                  bypass,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [COMP*WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  en,
    output logic                  valid,
    output logic [COMP*WIDTH-1:0] data,
    output logic                  last
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] HALF  = 1'b1;

    logic [0:0]            state;
    logic [COMP*WIDTH-1:0] hold;
    logic                  sol;
    logic                  line_byp;
    logic                  cur_byp;
    logic                  accept;
    logic                  produce;
    logic [COMP*WIDTH-1:0] avg;
    logic [COMP*WIDTH-1:0] out_next;
    logic [WIDTH:0]        sum;

    assign in_ready = ~valid | en;
    assign accept   = in_valid & in_ready & ~clr;
    // First pixel of a line uses the live bypass input; the flag takes effect from then on.
    assign cur_byp  = sol ? bypass : line_byp;
    assign produce  = accept & (cur_byp | (state == HALF) | in_last);

    always_comb begin
        avg = '0;
        sum = '0;
        for (int k = 0; k < COMP; k++) begin
            sum = {1'b0, hold[k*WIDTH +: WIDTH]}
                + {1'b0, in_data[k*WIDTH +: WIDTH]}
                + {{WIDTH{1'b0}}, 1'b1};
            avg[k*WIDTH +: WIDTH] = sum[WIDTH:1];
        end
    end

    always_comb begin
        out_next = in_data;
        if (!cur_byp && state == HALF) begin
            out_next = avg;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            valid    <= 1'b0;
            data     <= '0;
            last     <= 1'b0;
            state    <= EMPTY;
            hold     <= '0;
            sol      <= 1'b1;
            line_byp <= 1'b0;
        end else if (clr) begin
            valid <= 1'b0;
            state <= EMPTY;
            sol   <= 1'b1;
        end else begin
            if (produce) begin
                valid <= 1'b1;
                data  <= out_next;
                last  <= in_last;
            end else if (valid && en) begin
                valid <= 1'b0;
            end
            if (accept) begin
                sol <= in_last;
                if (sol) begin
                    line_byp <= bypass;
                end
                if (!cur_byp && state == EMPTY && !in_last) begin
                    hold  <= in_data;
                    state <= HALF;
                end else begin
                    state <= EMPTY;
                end
            end
        end
    end

    a_stall_stable: assert property (
        @(posedge clk) disable iff (!nreset)
        (valid && !en && !clr) |=> ($stable(data) && $stable(last))
    );

    a_valid_known: assert property (
        @(posedge clk) disable iff (!nreset)
        !$isunknown(valid)
    );

endmodule

// File: tb/tb_dc_ipu_shr_hdecim2.sv
// Directed bench for the 2:1 horizontal decimator.
// Collects output transfers and compares against hand-computed pixel lists.
module tb_dc_ipu_shr_hdecim2;

    logic        clk = 1'b0;
    logic        nreset;
    logic        clr;
    logic        bypass;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        in_last;
    logic        en = 1'b1;
    logic        valid;
    logic [23:0] data;
    logic        last;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [24:0] q[$];
    logic [24:0] eq[$];
    logic        bp_mode = 1'b0;
    logic        en_man = 1'b1;
    int          pat[6] = '{1, 0, 1, 0, 0, 1};
    int          pi = 0;
    logic        stl = 1'b0;
    logic [24:0] saved;

    dc_ipu_shr_hdecim2 #(.WIDTH(8), .COMP(3)) dut (
        .clk(clk), .nreset(nreset), .clr(clr), .bypass(bypass),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .en(en), .valid(valid), .data(data),
        .last(last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            en = pat[pi][0];
            pi = (pi + 1) % 6;
        end else begin
            en = en_man;
        end
    end

    always @(negedge clk) begin
        if (nreset && valid && en) q.push_back({last, data});
        if (bp_mode) begin
            if (stl) chk("bp_hold", 32'({last, data}), 32'(saved));
            stl = valid & ~en;
            if (stl) begin
                chk("bp_rdy", 32'(in_ready), 32'd0);
                saved = {last, data};
            end
        end else begin
            stl = 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic px(input logic [23:0] d, input logic l);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("px_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic ex(input logic [23:0] d, input logic l);
        eq.push_back({l, d});
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_cnt"}, 32'(q.size()), 32'(eq.size()));
        for (int i = 0; i < eq.size(); i++) begin
            if (i < q.size())
                chk($sformatf("%s_%0d", tag, i), 32'(q[i]), 32'(eq[i]));
        end
        q.delete();
        eq.delete();
    endtask

    initial begin
        nreset = 1'b0; clr = 1'b0; bypass = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        #3;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 nreset = 1'b1;
        idle(2);

        // even line
        px(24'h102030, 0); px(24'h304050, 0);
        px(24'h050607, 0); px(24'h07090B, 1);
        idle(4);
        ex(24'h203040, 0); ex(24'h060809, 1);
        check_outs("even");

        // odd line, then a line proving restart in EMPTY
        px(24'h0A0A0A, 0); px(24'h0C0C0C, 0); px(24'hFFFFFF, 1);
        idle(4);
        ex(24'h0B0B0B, 0); ex(24'hFFFFFF, 1);
        check_outs("odd");

        // rounding at both ends of the range
        px(24'hFFFFFF, 0); px(24'hFEFEFE, 0);
        px(24'h000000, 0); px(24'h010101, 1);
        idle(4);
        ex(24'hFFFFFF, 0); ex(24'h010101, 1);
        check_outs("round");

        // bypass line, flag dropped mid-line, then decimated line
        bypass = 1'b1;
        px(24'h111111, 0); px(24'h222222, 0);
        bypass = 1'b0;
        px(24'h333333, 0); px(24'h444444, 0); px(24'h555555, 1);
        px(24'h020202, 0); px(24'h040404, 1);
        idle(4);
        ex(24'h111111, 0); ex(24'h222222, 0); ex(24'h333333, 0);
        ex(24'h444444, 0); ex(24'h555555, 1); ex(24'h030303, 1);
        check_outs("byp");

        // backpressure over a 16-pixel line
        bp_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] v;
            v = 8'(i * 10);
            px({v, v, v}, i == 15);
        end
        idle(24);
        bp_mode = 1'b0;
        idle(2);
        for (int j = 0; j < 8; j++) begin
            logic [7:0] a;
            a = 8'(20 * j + 5);
            ex({a, a, a}, j == 7);
        end
        check_outs("bp");

        // clr in HALF discards the held pixel and the concurrent input
        px(24'h101010, 0);
        in_valid = 1'b1; in_data = 24'hEEEEEE; clr = 1'b1;
        idle(1);
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_valid", 32'(valid), 32'd0);
        px(24'h505050, 0); px(24'h707070, 1);
        idle(4);
        ex(24'h606060, 1);
        check_outs("clr");

        // async reset mid-line with a stalled output
        en_man = 1'b0;
        idle(2);
        px(24'h101010, 0); px(24'h303030, 0);
        in_valid = 1'b1; in_data = 24'h909090;
        idle(1);
        chk("pre_rst_valid", 32'(valid), 32'd1);
        #2 nreset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_data", 32'(data), 32'd0);
        chk("mid_rst_rdy", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        en_man = 1'b1;
        @(posedge clk);
        #1 nreset = 1'b1;
        idle(2);
        q.delete();
        px(24'h505050, 0); px(24'h707070, 1);
        idle(4);
        ex(24'h606060, 1);
        check_outs("rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
